// File: rtl/pc_unit_pkg.sv
// Shared constants, selector/RAS encodings and the RAS op decoder for the fetch-stage PC unit.
package pc_unit_pkg;

  // Instruction alignment mask applied to redirect targets
  localparam logic [1:0]  ALIGN_MASK = 2'b11;
  // Sequential PC increment in bytes
  localparam int unsigned PC_INC     = 4;
  // Width of the post-reset hold counter (RST_HOLD range 0..15)
  localparam int unsigned HOLD_W     = 4;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_CSR,
    SEL_ALU,
    SEL_HOLD,
    SEL_SEQ
  } pc_sel_e;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_REPLACE
  } ras_op_e;

  // Map call/return qualifiers of an enabled jump onto a RAS operation
  function automatic ras_op_e ras_decode(input logic en, input logic call, input logic ret);
    ras_op_e op;
    op = RAS_NONE;
    if (en) begin
      case ({call, ret})
        2'b10:   op = RAS_PUSH;
        2'b01:   op = RAS_POP;
        2'b11:   op = RAS_REPLACE;
        default: op = RAS_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored, replace rewrites the top (or pushes when empty).
module pc_ras
  import pc_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  ras_op_e          op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic             valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             wr_en;
  logic [WIDTH-1:0] top_d;

  // Next pointer/count and write enable for the requested operation
  always_comb begin
    ptr_d = ptr;
    cnt_d = cnt;
    wr_en = 1'b0;
    case (op)
      RAS_PUSH: begin
        ptr_d = ptr + PTR_W'(1);
        wr_en = 1'b1;
        if (cnt != CNT_W'(DEPTH)) cnt_d = cnt + CNT_W'(1);
      end
      RAS_POP: begin
        if (cnt != '0) begin
          ptr_d = ptr - PTR_W'(1);
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RAS_REPLACE: begin
        wr_en = 1'b1;
        if (cnt == '0) cnt_d = CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Top-of-stack value after this cycle's update (write data bypasses the array)
  always_comb begin
    top_d = '0;
    if (cnt_d != '0) top_d = wr_en ? data : mem[ptr_d];
  end

  // Stack storage, pointer, count and registered top/valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      ptr   <= '0;
      cnt   <= '0;
      top   <= '0;
      valid <= 1'b0;
    end else begin
      if (wr_en) mem[ptr_d] <= data;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      top   <= top_d;
      valid <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program-counter generator: prioritised next-PC selection,
// post-reset hold, misaligned-redirect flagging and return-address prediction.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned           OPD_WIDTH    = 32,
  parameter int unsigned           PC_WIDTH     = 12,
  parameter logic [OPD_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned           RST_HOLD     = 1,
  parameter int unsigned           RAS_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch,
  input  logic                 comp_result,
  input  logic                 jump,
  input  logic                 is_call,
  input  logic                 is_ret,
  input  logic                 csr_sel,
  input  logic [OPD_WIDTH-1:0] alu_result,
  input  logic [OPD_WIDTH-1:0] csr_out,
  output logic [OPD_WIDTH-1:0] pc_out,
  output logic [OPD_WIDTH-1:0] pc_plus4,
  output logic [PC_WIDTH-1:0]  next_pc,
  output logic                 misalign,
  output logic [OPD_WIDTH-1:0] misalign_addr,
  output logic [OPD_WIDTH-1:0] ras_top,
  output logic                 ras_valid
);

  logic [HOLD_W-1:0]    hold_cnt;
  logic                 in_hold;
  logic                 taken;
  logic                 bad_target;
  pc_sel_e              sel;
  logic [OPD_WIDTH-1:0] target;
  logic                 ras_en;
  ras_op_e              ras_op;

  // Post-reset hold counter: loads on reset, counts down to zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= HOLD_W'(RST_HOLD);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  // Priority selection of the next PC source; misaligned ALU targets hold the PC
  always_comb begin
    in_hold    = rst | (hold_cnt != '0);
    taken      = (branch & comp_result) | jump;
    bad_target = taken & ~csr_sel & ((alu_result[1:0] & ALIGN_MASK) != 2'b00);
    sel        = SEL_SEQ;
    if (in_hold)               sel = SEL_RESET;
    else if (csr_sel)          sel = SEL_CSR;
    else if (taken && !bad_target) sel = SEL_ALU;
    else if (taken || stall)   sel = SEL_HOLD;
    else                       sel = SEL_SEQ;
  end

  // Target value for the selected source
  always_comb begin
    target = pc_out + OPD_WIDTH'(PC_INC);
    case (sel)
      SEL_RESET: target = RESET_VECTOR;
      SEL_CSR:   target = csr_out;
      SEL_ALU:   target = alu_result;
      SEL_HOLD:  target = pc_out;
      default:   target = pc_out + OPD_WIDTH'(PC_INC);
    endcase
    next_pc = target[PC_WIDTH-1:0];
  end

  // PC register and its precomputed +4
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out   <= RESET_VECTOR;
      pc_plus4 <= RESET_VECTOR + OPD_WIDTH'(PC_INC);
    end else begin
      pc_out   <= target;
      pc_plus4 <= target + OPD_WIDTH'(PC_INC);
    end
  end

  // One-cycle misalignment flag with the offending target captured alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= bad_target & ~in_hold;
      if (bad_target && !in_hold) misalign_addr <= alu_result;
    end
  end

  // RAS moves only on an unstalled, non-trap jump outside the reset hold
  always_comb begin
    ras_en = jump & ~stall & ~csr_sel & ~in_hold;
    ras_op = ras_decode(ras_en, is_call, is_ret);
  end

  pc_ras #(
    .WIDTH (OPD_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .op    (ras_op),
    .data  (pc_plus4),
    .top   (ras_top),
    .valid (ras_valid)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a scoreboard of expected post-edge values.
module tb_pc_unit;

  localparam int unsigned OW = 32;
  localparam int unsigned PW = 12;

  typedef enum int {K_PC, K_PLUS4, K_NEXT, K_MIS, K_MADDR, K_TOP, K_VALID} kind_e;
  typedef struct {
    string   tag;
    kind_e   kind;
    logic [31:0] value;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, branch, comp_result, jump, is_call, is_ret, csr_sel;
  logic [OW-1:0] alu_result, csr_out;
  logic [OW-1:0] pc_out, pc_plus4, misalign_addr, ras_top;
  logic [PW-1:0] next_pc;
  logic          misalign, ras_valid;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  pc_unit #(
    .OPD_WIDTH    (OW),
    .PC_WIDTH     (PW),
    .RESET_VECTOR (32'h100),
    .RST_HOLD     (2),
    .RAS_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch        (branch),
    .comp_result   (comp_result),
    .jump          (jump),
    .is_call       (is_call),
    .is_ret        (is_ret),
    .csr_sel       (csr_sel),
    .alu_result    (alu_result),
    .csr_out       (csr_out),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .ras_top       (ras_top),
    .ras_valid     (ras_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(kind_e k);
    case (k)
      K_PC:    return pc_out;
      K_PLUS4: return pc_plus4;
      K_NEXT:  return 32'(next_pc);
      K_MIS:   return 32'(misalign);
      K_MADDR: return misalign_addr;
      K_TOP:   return ras_top;
      default: return 32'(ras_valid);
    endcase
  endfunction

  task automatic expect_val(input string tag, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.value = v;
    sb.push_back(e);
  endtask

  task automatic exp_state(input string tag, input logic [31:0] pc, input logic mis,
                           input logic [31:0] top, input logic valid);
    expect_val({tag, ".pc"},    K_PC,    pc);
    expect_val({tag, ".plus4"}, K_PLUS4, pc + 32'd4);
    expect_val({tag, ".mis"},   K_MIS,   32'(mis));
    expect_val({tag, ".top"},   K_TOP,   top);
    expect_val({tag, ".valid"}, K_VALID, 32'(valid));
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind);
      tests++;
      assert (obs === e.value) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic set_in(input logic b, input logic c, input logic j, input logic call,
                        input logic ret, input logic st, input logic cs,
                        input logic [31:0] alu, input logic [31:0] csr);
    branch = b; comp_result = c; jump = j; is_call = call; is_ret = ret;
    stall = st; csr_sel = cs; alu_result = alu; csr_out = csr;
  endtask

  initial begin
    logic [31:0] pops [5];
    pops[0] = 32'h44; pops[1] = 32'h34; pops[2] = 32'h24; pops[3] = 32'h0; pops[4] = 32'h0;

    // Reset and post-reset hold (a jump/call during hold is ignored)
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    exp_state("reset", 32'h100, 0, 32'h0, 0);
    expect_val("reset.maddr", K_MADDR, 32'h0);
    tick();
    expect_val("rst_next", K_NEXT, 32'h100);
    settle();

    rst = 1'b0;
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h300, 32'h0);
    expect_val("hold1_next", K_NEXT, 32'h100);
    settle();
    exp_state("hold1", 32'h100, 0, 32'h0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    expect_val("hold2_next", K_NEXT, 32'h100);
    settle();
    exp_state("hold2", 32'h100, 0, 32'h0, 0);
    tick();
    expect_val("seq1_next", K_NEXT, 32'h104);
    settle();
    exp_state("seq1", 32'h104, 0, 32'h0, 0);
    tick();
    expect_val("seq2_next", K_NEXT, 32'h108);
    settle();
    exp_state("seq2", 32'h108, 0, 32'h0, 0);
    tick();

    // Taken branch overrides stall; untaken branch with stall holds
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h20, 32'h0);
    exp_state("jmp20", 32'h20, 0, 32'h0, 0);
    tick();
    set_in(1, 1, 0, 0, 0, 1, 0, 32'h80, 32'h0);
    expect_val("br_taken_next", K_NEXT, 32'h080);
    settle();
    exp_state("br_taken", 32'h80, 0, 32'h0, 0);
    tick();
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h20, 32'h0);
    exp_state("jmp20b", 32'h20, 0, 32'h0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 1, 0, 32'h80, 32'h0);
    expect_val("br_nt_stall_next", K_NEXT, 32'h020);
    settle();
    exp_state("br_nt_stall", 32'h20, 0, 32'h0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 32'h80, 32'h0);
    exp_state("br_nt", 32'h24, 0, 32'h0, 0);
    tick();

    // Misaligned jump holds PC and flags for exactly one cycle
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h82, 32'h0);
    expect_val("mis_next", K_NEXT, 32'h024);
    settle();
    exp_state("mis", 32'h24, 1, 32'h0, 0);
    expect_val("mis.maddr", K_MADDR, 32'h82);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    exp_state("mis_clr", 32'h28, 0, 32'h0, 0);
    tick();

    // CSR redirect wins over jump, blocks RAS, and is never alignment-checked
    set_in(0, 0, 1, 1, 0, 0, 1, 32'h90, 32'h40);
    exp_state("csr", 32'h40, 0, 32'h0, 0);
    tick();
    set_in(0, 0, 1, 0, 0, 0, 1, 32'h83, 32'h42);
    exp_state("csr_odd", 32'h42, 0, 32'h0, 0);
    tick();

    // Five calls into a four-deep RAS; oldest entry is overwritten
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h10, 32'h0);
    exp_state("jmp10", 32'h10, 0, 32'h0, 0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      set_in(0, 0, 1, 1, 0, 0, 0, 32'((i + 1) * 16), 32'h0);
      exp_state($sformatf("call%0d", i), 32'((i + 1) * 16), 0, 32'(i * 16 + 4), 1);
      tick();
    end
    // Stalled call still redirects but leaves the RAS alone
    set_in(0, 0, 1, 1, 0, 1, 0, 32'h70, 32'h0);
    exp_state("call_stall", 32'h70, 0, 32'h54, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 1, 0, 1, 0, 0, 32'h200, 32'h0);
      exp_state($sformatf("ret%0d", i + 1), 32'h200, 0, pops[i], (i < 3) ? 1'b1 : 1'b0);
      tick();
    end

    // Call+return replaces the top; reset mid-sequence clears everything
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h10, 32'h0);
    exp_state("jmp10b", 32'h10, 0, 32'h0, 0);
    tick();
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h20, 32'h0);
    exp_state("callA", 32'h20, 0, 32'h14, 1);
    tick();
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h60, 32'h0);
    exp_state("callB", 32'h60, 0, 32'h24, 1);
    tick();
    set_in(0, 0, 1, 1, 1, 0, 0, 32'h70, 32'h0);
    exp_state("callret", 32'h70, 0, 32'h64, 1);
    tick();
    set_in(0, 0, 1, 0, 1, 0, 0, 32'h80, 32'h0);
    exp_state("ret_after_replace", 32'h80, 0, 32'h14, 1);
    tick();
    rst = 1'b1;
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h82, 32'h0);
    expect_val("midrst_next", K_NEXT, 32'h100);
    settle();
    exp_state("midrst", 32'h100, 0, 32'h0, 0);
    expect_val("midrst.maddr", K_MADDR, 32'h0);
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    exp_state("post_rst", 32'h100, 0, 32'h0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
